id_ex_stage: RTL and testbench

//  ID/EX pipeline register plus execute-stage operand forwarding, sitting directly upstream of the ALU.

---
 rtl/riscv_pipe_pkg.sv | 58 +++++
 rtl/id_ex_stage_if.sv | 65 ++++++
 rtl/id_ex_stage_forward_unit.sv | 19 +
 rtl/id_ex_stage.sv | 95 +++++++++
 tb/tb_id_ex_stage.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline constants: datapath widths, forward selects, ALU codes
// and the ID/EX register bundle.
package riscv_pipe_pkg;

   localparam int XLEN      = 32;
   localparam int REG_AW    = 5;
   localparam int ALUCTRL_W = 4;

   // Operand source chosen by the forwarding logic.
   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_e;

   // ALU operation codes carried through the pipeline.
   localparam logic [ALUCTRL_W-1:0] ALU_AND = 4'b0000;
   localparam logic [ALUCTRL_W-1:0] ALU_OR  = 4'b0001;
   localparam logic [ALUCTRL_W-1:0] ALU_ADD = 4'b0010;
   localparam logic [ALUCTRL_W-1:0] ALU_SUB = 4'b0110;
   localparam logic [ALUCTRL_W-1:0] ALU_SLT = 4'b0111;
   localparam logic [ALUCTRL_W-1:0] ALU_NOR = 4'b1100;

   // Everything the ID/EX register captures from decode.
   typedef struct packed {
      logic                 valid;
      logic                 reg_write;
      logic                 mem_read;
      logic                 mem_write;
      logic                 alu_src;
      logic [ALUCTRL_W-1:0] alu_ctrl;
      logic [XLEN-1:0]      pc;
      logic [XLEN-1:0]      rd1;
      logic [XLEN-1:0]      rd2;
      logic [XLEN-1:0]      imm;
      logic [REG_AW-1:0]    rs1;
      logic [REG_AW-1:0]    rs2;
      logic [REG_AW-1:0]    rd;
   } id_ex_t;

   localparam int ID_EX_W = $bits(id_ex_t);

   // MEM has the younger result, so it beats WB; x0 is never forwarded.
   function automatic fwd_sel_e fwd_select(
      input logic              valid_e,
      input logic [REG_AW-1:0] rs_e,
      input logic [REG_AW-1:0] rd_m,
      input logic              reg_write_m,
      input logic [REG_AW-1:0] rd_w,
      input logic              reg_write_w
   );
      if (!valid_e)                                          return FWD_RF;
      else if (reg_write_m && rd_m != '0 && rd_m == rs_e)    return FWD_MEM;
      else if (reg_write_w && rd_w != '0 && rd_w == rs_e)    return FWD_WB;
      else                                                   return FWD_RF;
   endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode, forward-source and execute-side signals of the ID/EX stage.
// The slave modport is the stage itself; master is its environment.
interface id_ex_stage_if;
   import riscv_pipe_pkg::*;

   logic                 i_valid_d;
   logic                 i_stall;
   logic                 i_flush;
   logic [XLEN-1:0]      i_pc_d;
   logic [XLEN-1:0]      i_rd1_d;
   logic [XLEN-1:0]      i_rd2_d;
   logic [XLEN-1:0]      i_imm_d;
   logic [REG_AW-1:0]    i_rs1_d;
   logic [REG_AW-1:0]    i_rs2_d;
   logic [REG_AW-1:0]    i_rd_d;
   logic [ALUCTRL_W-1:0] i_alu_ctrl_d;
   logic                 i_alu_src_d;
   logic                 i_reg_write_d;
   logic                 i_mem_read_d;
   logic                 i_mem_write_d;
   logic [REG_AW-1:0]    i_rd_m;
   logic                 i_reg_write_m;
   logic [XLEN-1:0]      i_alu_result_m;
   logic [REG_AW-1:0]    i_rd_w;
   logic                 i_reg_write_w;
   logic [XLEN-1:0]      i_result_w;

   logic [XLEN-1:0]      o_A_e;
   logic [XLEN-1:0]      o_B_e;
   logic [XLEN-1:0]      o_write_data_e;
   logic [ALUCTRL_W-1:0] o_alu_ctrl_e;
   logic [XLEN-1:0]      o_pc_e;
   logic [XLEN-1:0]      o_imm_e;
   logic [REG_AW-1:0]    o_rd_e;
   logic                 o_valid_e;
   logic                 o_reg_write_e;
   logic                 o_mem_read_e;
   logic                 o_mem_write_e;
   logic [1:0]           o_fwd_a_e;
   logic [1:0]           o_fwd_b_e;
   logic                 o_stall_fd;

   modport slave (
      input  i_valid_d, i_stall, i_flush, i_pc_d, i_rd1_d, i_rd2_d, i_imm_d,
             i_rs1_d, i_rs2_d, i_rd_d, i_alu_ctrl_d, i_alu_src_d,
             i_reg_write_d, i_mem_read_d, i_mem_write_d,
             i_rd_m, i_reg_write_m, i_alu_result_m,
             i_rd_w, i_reg_write_w, i_result_w,
      output o_A_e, o_B_e, o_write_data_e, o_alu_ctrl_e, o_pc_e, o_imm_e,
             o_rd_e, o_valid_e, o_reg_write_e, o_mem_read_e, o_mem_write_e,
             o_fwd_a_e, o_fwd_b_e, o_stall_fd
   );

   modport master (
      output i_valid_d, i_stall, i_flush, i_pc_d, i_rd1_d, i_rd2_d, i_imm_d,
             i_rs1_d, i_rs2_d, i_rd_d, i_alu_ctrl_d, i_alu_src_d,
             i_reg_write_d, i_mem_read_d, i_mem_write_d,
             i_rd_m, i_reg_write_m, i_alu_result_m,
             i_rd_w, i_reg_write_w, i_result_w,
      input  o_A_e, o_B_e, o_write_data_e, o_alu_ctrl_e, o_pc_e, o_imm_e,
             o_rd_e, o_valid_e, o_reg_write_e, o_mem_read_e, o_mem_write_e,
             o_fwd_a_e, o_fwd_b_e, o_stall_fd
   );

endinterface

// File: rtl/id_ex_stage_forward_unit.sv
// Forward-select generation for both ALU operands of the EX instruction.
module forward_unit
   import riscv_pipe_pkg::*;
(
   input  logic              valid_e,
   input  logic [REG_AW-1:0] rs1_e,
   input  logic [REG_AW-1:0] rs2_e,
   input  logic [REG_AW-1:0] rd_m,
   input  logic              reg_write_m,
   input  logic [REG_AW-1:0] rd_w,
   input  logic              reg_write_w,
   output fwd_sel_e          fwd_a,
   output fwd_sel_e          fwd_b
);

   assign fwd_a = fwd_select(valid_e, rs1_e, rd_m, reg_write_m, rd_w, reg_write_w);
   assign fwd_b = fwd_select(valid_e, rs2_e, rd_m, reg_write_m, rd_w, reg_write_w);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and MEM/WB
// operand forwarding feeding the ALU.
module id_ex_stage
   import riscv_pipe_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   id_ex_stage_if.slave bus
);

   id_ex_t   ex_q;
   id_ex_t   ex_load;
   fwd_sel_e fwd_a;
   fwd_sel_e fwd_b;
   logic     load_use;
   logic [XLEN-1:0] opnd_a;
   logic [XLEN-1:0] opnd_b;

   // Load-use hazard: the EX load's destination is read by the decode slot.
   assign load_use = bus.i_valid_d && ex_q.valid && ex_q.mem_read && ex_q.rd != '0 &&
                     (ex_q.rd == bus.i_rs1_d || ex_q.rd == bus.i_rs2_d);
   assign bus.o_stall_fd = !bus.i_flush && load_use;

   // Decode fields as they would be captured; a non-instruction slot never writes.
   always_comb begin
      // NOTE: give every always_comb target a default first so no path can infer a latch.
      ex_load           = '0;
      ex_load.valid     = bus.i_valid_d;
      ex_load.reg_write = bus.i_valid_d && bus.i_reg_write_d;
      ex_load.mem_read  = bus.i_valid_d && bus.i_mem_read_d;
      ex_load.mem_write = bus.i_valid_d && bus.i_mem_write_d;
      ex_load.alu_src   = bus.i_alu_src_d;
      ex_load.alu_ctrl  = bus.i_alu_ctrl_d;
      ex_load.pc        = bus.i_pc_d;
      ex_load.rd1       = bus.i_rd1_d;
      ex_load.rd2       = bus.i_rd2_d;
      ex_load.imm       = bus.i_imm_d;
      ex_load.rs1       = bus.i_rs1_d;
      ex_load.rs2       = bus.i_rs2_d;
      ex_load.rd        = bus.i_rd_d;
   end

   // EX register: flush beats stall beats load-use bubble beats normal load.
   always_ff @(posedge i_clk or posedge i_rst) begin
      // NOTE: state registers use non-blocking assignments and clear on the async reset edge.
      if (i_rst)             ex_q <= '0;
      else if (bus.i_flush)  ex_q <= '0;
      else if (bus.i_stall)  ex_q <= ex_q;
      else if (load_use)     ex_q <= '0;
      else                   ex_q <= ex_load;
   end

   forward_unit u_forward_unit (
      .valid_e     (ex_q.valid),
      .rs1_e       (ex_q.rs1),
      .rs2_e       (ex_q.rs2),
      .rd_m        (bus.i_rd_m),
      .reg_write_m (bus.i_reg_write_m),
      .rd_w        (bus.i_rd_w),
      .reg_write_w (bus.i_reg_write_w),
      .fwd_a       (fwd_a),
      .fwd_b       (fwd_b)
   );

   // Operand muxes driven by the forward selects.
   always_comb begin
      opnd_a = ex_q.rd1;
      opnd_b = ex_q.rd2;
      case (fwd_a)
         FWD_MEM: opnd_a = bus.i_alu_result_m;
         FWD_WB:  opnd_a = bus.i_result_w;
         default: opnd_a = ex_q.rd1;
      endcase
      case (fwd_b)
         FWD_MEM: opnd_b = bus.i_alu_result_m;
         FWD_WB:  opnd_b = bus.i_result_w;
         default: opnd_b = ex_q.rd2;
      endcase
   end

   assign bus.o_A_e          = opnd_a;
   assign bus.o_B_e          = ex_q.alu_src ? ex_q.imm : opnd_b;
   assign bus.o_write_data_e = opnd_b;
   assign bus.o_alu_ctrl_e   = ex_q.alu_ctrl;
   assign bus.o_pc_e         = ex_q.pc;
   assign bus.o_imm_e        = ex_q.imm;
   assign bus.o_rd_e         = ex_q.rd;
   assign bus.o_valid_e      = ex_q.valid;
   assign bus.o_reg_write_e  = ex_q.reg_write;
   assign bus.o_mem_read_e   = ex_q.mem_read;
   assign bus.o_mem_write_e  = ex_q.mem_write;
   assign bus.o_fwd_a_e      = fwd_a;
   assign bus.o_fwd_b_e      = fwd_b;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: forwarding, load-use bubble, flush/stall
// priority and asynchronous reset, with hand-computed expected values.
module tb_id_ex_stage;
   import riscv_pipe_pkg::*;

   logic i_clk = 1'b0;
   logic i_rst = 1'b1;
   int   tests_run    = 0;
   int   tests_failed = 0;

   id_ex_stage_if bus ();

   id_ex_stage dut (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .bus   (bus)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.i_valid_d = 0; bus.i_stall = 0; bus.i_flush = 0;
      bus.i_pc_d = '0; bus.i_rd1_d = '0; bus.i_rd2_d = '0; bus.i_imm_d = '0;
      bus.i_rs1_d = '0; bus.i_rs2_d = '0; bus.i_rd_d = '0;
      bus.i_alu_ctrl_d = ALU_AND; bus.i_alu_src_d = 0;
      bus.i_reg_write_d = 0; bus.i_mem_read_d = 0; bus.i_mem_write_d = 0;
      bus.i_rd_m = '0; bus.i_reg_write_m = 0; bus.i_alu_result_m = '0;
      bus.i_rd_w = '0; bus.i_reg_write_w = 0; bus.i_result_w = '0;
   endtask

   task automatic decode(input logic [31:0] pc, input logic [4:0] rs1, input logic [31:0] rd1,
                         input logic [4:0] rs2, input logic [31:0] rd2, input logic [4:0] rd,
                         input logic mem_read);
      bus.i_valid_d = 1; bus.i_pc_d = pc;
      bus.i_rs1_d = rs1; bus.i_rd1_d = rd1;
      bus.i_rs2_d = rs2; bus.i_rd2_d = rd2;
      bus.i_rd_d = rd; bus.i_alu_ctrl_d = ALU_ADD;
      bus.i_reg_write_d = 1; bus.i_mem_read_d = mem_read;
   endtask

   task automatic check_all_zero(input string tag);
      logic [31:0] ored;
      ored = bus.o_A_e | bus.o_B_e | bus.o_write_data_e | bus.o_pc_e | bus.o_imm_e |
             32'(bus.o_alu_ctrl_e) | 32'(bus.o_rd_e) | 32'(bus.o_fwd_a_e) | 32'(bus.o_fwd_b_e) |
             32'({bus.o_valid_e, bus.o_reg_write_e, bus.o_mem_read_e, bus.o_mem_write_e,
                  bus.o_stall_fd});
      check(tag, ored, 32'h0);
   endtask

   initial begin
      clear_inputs();
      #3;
      check_all_zero("reset_outputs");
      @(negedge i_clk);
      i_rst = 1'b0;

      // Plain load with no forward, then MEM forward onto operand A.
      decode(32'h40, 5'd3, 32'd5, 5'd0, 32'd0, 5'd1, 1'b0);
      tick();
      check("a_no_fwd", bus.o_A_e, 32'd5);
      check("fwd_a_rf", 32'(bus.o_fwd_a_e), 32'(FWD_RF));
      check("pc_e", bus.o_pc_e, 32'h40);
      check("alu_ctrl_e", 32'(bus.o_alu_ctrl_e), 32'(ALU_ADD));
      check("valid_e", 32'(bus.o_valid_e), 32'd1);
      bus.i_rd_m = 5'd3; bus.i_reg_write_m = 1; bus.i_alu_result_m = 32'h20;
      #1;
      check("a_fwd_mem", bus.o_A_e, 32'h20);
      check("fwd_a_mem", 32'(bus.o_fwd_a_e), 32'(FWD_MEM));
      bus.i_reg_write_m = 0;
      bus.i_rd_w = 5'd3; bus.i_reg_write_w = 1; bus.i_result_w = 32'h44;
      #1;
      check("a_fwd_wb", bus.o_A_e, 32'h44);
      check("fwd_a_wb", 32'(bus.o_fwd_a_e), 32'(FWD_WB));

      // MEM beats WB on operand B; immediate select keeps store data forwarded.
      clear_inputs();
      decode(32'h44, 5'd0, 32'd0, 5'd4, 32'h55, 5'd2, 1'b0);
      tick();
      bus.i_rd_m = 5'd4; bus.i_reg_write_m = 1; bus.i_alu_result_m = 32'h11;
      bus.i_rd_w = 5'd4; bus.i_reg_write_w = 1; bus.i_result_w = 32'h22;
      #1;
      check("b_fwd_mem", bus.o_B_e, 32'h11);
      check("fwd_b_mem", 32'(bus.o_fwd_b_e), 32'(FWD_MEM));
      bus.i_alu_src_d = 1; bus.i_imm_d = 32'd7;
      tick();
      check("b_imm", bus.o_B_e, 32'd7);
      check("wdata_fwd", bus.o_write_data_e, 32'h11);
      check("imm_e", bus.o_imm_e, 32'd7);

      // x0 is never forwarded.
      clear_inputs();
      bus.i_rd_m = 5'd0; bus.i_reg_write_m = 1; bus.i_alu_result_m = 32'hDEAD;
      decode(32'h48, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 1'b0);
      tick();
      check("x0_a", bus.o_A_e, 32'd0);
      check("x0_fwd_a", 32'(bus.o_fwd_a_e), 32'(FWD_RF));
      check("x0_rd_write", 32'(bus.o_reg_write_e), 32'd1);

      // Invalid slot: control forced off, no forwarding.
      clear_inputs();
      bus.i_rs1_d = 5'd8; bus.i_reg_write_d = 1; bus.i_mem_write_d = 1; bus.i_pc_d = 32'h4C;
      bus.i_rd_m = 5'd8; bus.i_reg_write_m = 1; bus.i_alu_result_m = 32'h77;
      tick();
      check("inv_ctrl", 32'({bus.o_valid_e, bus.o_reg_write_e, bus.o_mem_write_e}), 32'd0);
      check("inv_pc", bus.o_pc_e, 32'h4C);
      check("inv_no_fwd", 32'(bus.o_fwd_a_e), 32'(FWD_RF));

      // Load-use: bubble, then WB forward supplies the load result.
      clear_inputs();
      decode(32'h50, 5'd1, 32'd0, 5'd2, 32'd0, 5'd6, 1'b1);
      tick();
      decode(32'h54, 5'd6, 32'd1, 5'd0, 32'd0, 5'd7, 1'b0);
      #1;
      check("lu_stall", 32'(bus.o_stall_fd), 32'd1);
      tick();
      check("lu_bubble_ctrl", 32'({bus.o_valid_e, bus.o_reg_write_e, bus.o_mem_read_e,
                                   bus.o_mem_write_e}), 32'd0);
      check("lu_bubble_pc", bus.o_pc_e, 32'd0);
      check("lu_stall_drop", 32'(bus.o_stall_fd), 32'd0);
      tick();
      check("lu_consumer_rd", 32'(bus.o_rd_e), 32'd7);
      bus.i_rd_w = 5'd6; bus.i_reg_write_w = 1; bus.i_result_w = 32'h99;
      #1;
      check("lu_a_wb", bus.o_A_e, 32'h99);

      // Flush with stall and hazard: flush wins.
      clear_inputs();
      decode(32'h60, 5'd1, 32'd0, 5'd2, 32'd0, 5'd6, 1'b1);
      tick();
      decode(32'h64, 5'd6, 32'd0, 5'd0, 32'd0, 5'd7, 1'b0);
      bus.i_flush = 1; bus.i_stall = 1;
      #1;
      check("flush_stall_fd", 32'(bus.o_stall_fd), 32'd0);
      tick();
      check("flush_bubble", 32'({bus.o_valid_e, bus.o_mem_read_e, bus.o_reg_write_e}), 32'd0);
      check("flush_pc", bus.o_pc_e, 32'd0);

      // Stall alone holds contents for three cycles.
      clear_inputs();
      decode(32'h100, 5'd1, 32'd3, 5'd2, 32'd4, 5'd9, 1'b0);
      tick();
      decode(32'h200, 5'd5, 32'd8, 5'd5, 32'd8, 5'd10, 1'b0);
      bus.i_stall = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("hold_pc_%0d", i), bus.o_pc_e, 32'h100);
         check($sformatf("hold_rd_%0d", i), 32'(bus.o_rd_e), 32'd9);
      end

      // Stall with hazard: hold first, bubble once the stall releases.
      clear_inputs();
      decode(32'h70, 5'd1, 32'd0, 5'd2, 32'd0, 5'd6, 1'b1);
      tick();
      decode(32'h74, 5'd0, 32'd0, 5'd6, 32'd0, 5'd7, 1'b0);
      bus.i_stall = 1;
      tick();
      check("sh_held_load", 32'({bus.o_mem_read_e, bus.o_rd_e}), 32'({1'b1, 5'd6}));
      check("sh_stall_fd", 32'(bus.o_stall_fd), 32'd1);
      bus.i_stall = 0;
      tick();
      check("sh_bubble", 32'({bus.o_valid_e, bus.o_mem_read_e}), 32'd0);

      // Asynchronous reset mid-run, away from any clock edge.
      clear_inputs();
      decode(32'h80, 5'd1, 32'h12, 5'd2, 32'h34, 5'd6, 1'b1);
      tick();
      decode(32'h84, 5'd6, 32'd0, 5'd0, 32'd0, 5'd7, 1'b0);
      #2;
      i_rst = 1'b1;
      #1;
      check_all_zero("async_reset");
      clear_inputs();
      #5;
      i_rst = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // Bound the run so a broken DUT can never hang the bench.
   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
